// File: rtl/demixer.sv
// ----------------------------------------------------------------------------
// demixer -- coherent QPSK demodulator (integrate-and-dump).
//
// Each accepted sample is multiplied by the local cosine and sine references
// (stage 1). The products are summed per branch over one symbol of
// SAMPLES_PER_SYMBOL accepted samples (stage 2). At the symbol boundary a
// sign decision per branch gives the 2-bit symbol, strobed by data_valid
// two cycles after the symbol's last sample was accepted.
//
// Parameters:
//   SAMPLES_PER_SYMBOL  accepted samples per symbol (>= 1)
//   ACC_W               accumulator width, 32 + clog2(SAMPLES_PER_SYMBOL)
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   signal_in     received sample, signed 16 bit
//   sine_in       local sine reference, signed 16 bit
//   cosine_in     local cosine reference, signed 16 bit
//   sample_valid  the three inputs above are valid this cycle
//   sync          symbol realign: current sample becomes sample 0
//   data_out      decided symbol, bit0 = cosine branch, bit1 = sine branch
//   data_valid    one-cycle strobe marking a new data_out
//   soft_cos_out  final cosine-branch sum (only with DEMIXER_SOFT_OUT_EN)
//   soft_sin_out  final sine-branch sum   (only with DEMIXER_SOFT_OUT_EN)
//
// Build option:
//   DEMIXER_SOFT_OUT_EN  adds the soft_*_out ports and their registers.
// ----------------------------------------------------------------------------
module demixer #(
    parameter  int SAMPLES_PER_SYMBOL = 16,
    localparam int ACC_W              = 32 + $clog2(SAMPLES_PER_SYMBOL)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [15:0]      signal_in,
    input  logic signed [15:0]      sine_in,
    input  logic signed [15:0]      cosine_in,
    input  logic                    sample_valid,
    input  logic                    sync,
    output logic [1:0]              data_out,
    output logic                    data_valid
`ifdef DEMIXER_SOFT_OUT_EN
    ,
    output logic signed [ACC_W-1:0] soft_cos_out,
    output logic signed [ACC_W-1:0] soft_sin_out
`endif
);

    localparam int CNT_W = (SAMPLES_PER_SYMBOL > 1) ? $clog2(SAMPLES_PER_SYMBOL) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SAMPLES_PER_SYMBOL - 1);

    // Sample counter and stage-1 (product) registers.
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [31:0]      prod_cos_q, prod_cos_d;
    logic signed [31:0]      prod_sin_q, prod_sin_d;
    logic                    s1_valid_q, s1_valid_d;
    logic                    s1_last_q, s1_last_d;

    // Stage-2 accumulators and the registered outputs.
    logic signed [ACC_W-1:0] acc_cos_q, acc_cos_d;
    logic signed [ACC_W-1:0] acc_sin_q, acc_sin_d;
    logic [1:0]              data_out_q, data_out_d;
    logic                    data_valid_q, data_valid_d;
`ifdef DEMIXER_SOFT_OUT_EN
    logic signed [ACC_W-1:0] soft_cos_q, soft_cos_d;
    logic signed [ACC_W-1:0] soft_sin_q, soft_sin_d;
`endif

    // Index of the current sample, with sync forcing it to the symbol start.
    logic [CNT_W-1:0]        cnt_cur;
    logic                    is_last;
    // Branch totals including the product sitting in stage 1.
    logic signed [ACC_W-1:0] sum_cos, sum_sin;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        cnt_cur = sync ? '0 : cnt_q;
        is_last = (cnt_cur == LAST_IDX);

        cnt_d      = cnt_cur;
        prod_cos_d = prod_cos_q;
        prod_sin_d = prod_sin_q;
        s1_valid_d = sample_valid;
        s1_last_d  = sample_valid && is_last;
        if (sample_valid) begin
            cnt_d      = is_last ? '0 : cnt_cur + CNT_W'(1);
            prod_cos_d = signal_in * cosine_in;
            prod_sin_d = signal_in * sine_in;
        end

        // Sign-extend the product to the accumulator width before the add.
        sum_cos = acc_cos_q + ACC_W'(prod_cos_q);
        sum_sin = acc_sin_q + ACC_W'(prod_sin_q);

        acc_cos_d    = acc_cos_q;
        acc_sin_d    = acc_sin_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
`ifdef DEMIXER_SOFT_OUT_EN
        soft_cos_d   = soft_cos_q;
        soft_sin_d   = soft_sin_q;
`endif

        if (sync) begin
            // Drop the partial symbol, including the entry now in stage 1.
            acc_cos_d = '0;
            acc_sin_d = '0;
        end else if (s1_valid_q) begin
            if (s1_last_q) begin
                // A total of exactly zero decides 1 (non-negative).
                data_out_d   = {~sum_sin[ACC_W-1], ~sum_cos[ACC_W-1]};
                data_valid_d = 1'b1;
                acc_cos_d    = '0;
                acc_sin_d    = '0;
`ifdef DEMIXER_SOFT_OUT_EN
                soft_cos_d   = sum_cos;
                soft_sin_d   = sum_sin;
`endif
            end else begin
                acc_cos_d = sum_cos;
                acc_sin_d = sum_sin;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments; the product registers are
    // reset as well so a reset always leaves a fully defined, empty pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            prod_cos_q   <= '0;
            prod_sin_q   <= '0;
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            acc_cos_q    <= '0;
            acc_sin_q    <= '0;
            data_out_q   <= 2'b00;
            data_valid_q <= 1'b0;
`ifdef DEMIXER_SOFT_OUT_EN
            soft_cos_q   <= '0;
            soft_sin_q   <= '0;
`endif
        end else begin
            cnt_q        <= cnt_d;
            prod_cos_q   <= prod_cos_d;
            prod_sin_q   <= prod_sin_d;
            s1_valid_q   <= s1_valid_d;
            s1_last_q    <= s1_last_d;
            acc_cos_q    <= acc_cos_d;
            acc_sin_q    <= acc_sin_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
`ifdef DEMIXER_SOFT_OUT_EN
            soft_cos_q   <= soft_cos_d;
            soft_sin_q   <= soft_sin_d;
`endif
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
`ifdef DEMIXER_SOFT_OUT_EN
    assign soft_cos_out = soft_cos_q;
    assign soft_sin_out = soft_sin_q;
`endif

endmodule

// File: tb/tb_demixer.sv
// ----------------------------------------------------------------------------
// tb_demixer -- self-checking bench for demixer.
//
// A driver applies directed symbol streams (clean, gapped, zero, sync and
// reset mid-symbol, full scale) followed by randomized traffic. A reference
// model sums sample*reference products per symbol with plain 64-bit
// arithmetic and queues the expected decision together with the cycle it
// must appear in. A monitor on the falling edge pops and compares whenever
// data_valid is seen, and otherwise checks that data_out holds.
// ----------------------------------------------------------------------------
module tb_demixer;

    localparam int N     = 16;
    localparam int ACC_W = 32 + $clog2(N);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [15:0] signal_in = '0;
    logic signed [15:0] sine_in = '0;
    logic signed [15:0] cosine_in = '0;
    logic               sample_valid = 1'b0;
    logic               sync = 1'b0;
    logic [1:0]         data_out;
    logic               data_valid;
`ifdef DEMIXER_SOFT_OUT_EN
    logic signed [ACC_W-1:0] soft_cos_out;
    logic signed [ACC_W-1:0] soft_sin_out;
`endif

    demixer #(.SAMPLES_PER_SYMBOL(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .signal_in    (signal_in),
        .sine_in      (sine_in),
        .cosine_in    (cosine_in),
        .sample_valid (sample_valid),
        .sync         (sync),
        .data_out     (data_out),
        .data_valid   (data_valid)
`ifdef DEMIXER_SOFT_OUT_EN
        ,
        .soft_cos_out (soft_cos_out),
        .soft_sin_out (soft_sin_out)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------------------------------------------------------- model
    typedef struct {
        int          due;
        logic [1:0]  data;
        longint      sc;
        longint      ss;
    } exp_t;

    exp_t   exp_q[$];
    longint sum_c = 0;
    longint sum_s = 0;
    int     cnt = 0;
    int     reset_due = -1;

    // Called once per cycle with the inputs the DUT samples at the next edge.
    task automatic model_step(input int t);
        exp_t e;
        if (rst || sync) begin
            // A symbol whose last sample went in on the previous cycle has not
            // been decided yet; reset or sync throws it away.
            while (exp_q.size() > 0 && exp_q[$].due > t) void'(exp_q.pop_back());
            sum_c = 0;
            sum_s = 0;
            cnt   = 0;
            if (rst) begin
                reset_due = t + 1;
                return;
            end
        end
        if (sample_valid) begin
            sum_c += longint'(signal_in) * longint'(cosine_in);
            sum_s += longint'(signal_in) * longint'(sine_in);
            cnt++;
            if (cnt == N) begin
                e.due     = t + 2;
                e.data[0] = (sum_c >= 0);
                e.data[1] = (sum_s >= 0);
                e.sc      = sum_c;
                e.ss      = sum_s;
                exp_q.push_back(e);
                sum_c = 0;
                sum_s = 0;
                cnt   = 0;
            end
        end
    endtask

    // --------------------------------------------------------------- driver
    task automatic drive(input logic v, input logic signed [15:0] sig,
                         input logic signed [15:0] c, input logic signed [15:0] s,
                         input logic sy, input logic r);
        @(posedge clk);
        #1;
        sample_valid = v;
        signal_in    = sig;
        cosine_in    = c;
        sine_in      = s;
        sync         = sy;
        rst          = r;
        model_step(cyc);
    endtask

    // 16-sample-per-period reference, amplitude 16000.
    int sin_t[16] = '{0, 6123, 11314, 14782, 16000, 14782, 11314, 6123,
                      0, -6123, -11314, -14782, -16000, -14782, -11314, -6123};

    function automatic logic signed [15:0] sin_ref(input int i);
        return 16'(sin_t[i % 16]);
    endfunction

    function automatic logic signed [15:0] cos_ref(input int i);
        return 16'(sin_t[(i + 4) % 16]);
    endfunction

    function automatic logic signed [15:0] tx_sample(input logic [1:0] sym, input int i);
        int v;
        v = (sym[0] ? int'(cos_ref(i)) : -int'(cos_ref(i)))
          + (sym[1] ? int'(sin_ref(i)) : -int'(sin_ref(i)));
        return 16'(v);
    endfunction

    // Send samples [first, last] of a symbol; optional bubble before each
    // sample and optional sync on the first one.
    task automatic send_samples(input logic [1:0] sym, input int first, input int last,
                                input logic gaps, input logic sync_first);
        for (int i = first; i <= last; i++) begin
            if (gaps) drive(1'b0, 16'($urandom), 16'($urandom), 16'($urandom), 1'b0, 1'b0);
            drive(1'b1, tx_sample(sym, i), cos_ref(i), sin_ref(i),
                  sync_first && (i == first), 1'b0);
        end
    endtask

    // -------------------------------------------------------------- monitor
    logic [1:0] hold = 2'b00;
    logic       armed = 1'b0;
    exp_t       mon_e;

    always @(negedge clk) begin
        if (reset_due == cyc) begin
            check("reset data_out", data_out, 0);
            check("reset data_valid", data_valid, 0);
`ifdef DEMIXER_SOFT_OUT_EN
            check("reset soft_cos", soft_cos_out, 0);
            check("reset soft_sin", soft_sin_out, 0);
`endif
            hold  = 2'b00;
            armed = 1'b1;
        end else if (armed) begin
            if (data_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected strobe", data_valid, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("strobe cycle", cyc, mon_e.due);
                    check("data_out", data_out, mon_e.data);
`ifdef DEMIXER_SOFT_OUT_EN
                    check("soft_cos", soft_cos_out, mon_e.sc);
                    check("soft_sin", soft_sin_out, mon_e.ss);
`endif
                    hold = mon_e.data;
                end
            end else begin
                check("data_out hold", data_out, hold);
                if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                    mon_e = exp_q.pop_front();
                    check("missed strobe", data_valid, 1);
                end
            end
        end
    end

    // ------------------------------------------------------------- stimulus
    initial begin
        // Reset held for a few cycles.
        for (int i = 0; i < 3; i++) drive(1'b0, '0, '0, '0, 1'b0, 1'b1);
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);

        // Clean symbol stream, valid held high.
        for (int k = 0; k < 4; k++) send_samples(2'(k), 0, N - 1, 1'b0, 1'b0);

        // Same stream with a bubble before every sample.
        for (int k = 0; k < 4; k++) send_samples(2'(k), 0, N - 1, 1'b1, 1'b0);

        // Zero input for a whole symbol.
        for (int i = 0; i < N; i++) drive(1'b1, '0, cos_ref(i), sin_ref(i), 1'b0, 1'b0);

        // Sync on accepted sample 5 restarts the symbol there.
        send_samples(2'b01, 0, 4, 1'b0, 1'b0);
        send_samples(2'b10, 0, N - 1, 1'b0, 1'b1);

        // Reset after 7 samples, then a clean symbol.
        send_samples(2'b11, 0, 6, 1'b0, 1'b0);
        drive(1'b0, '0, '0, '0, 1'b0, 1'b1);
        send_samples(2'b01, 0, N - 1, 1'b0, 1'b0);

        // Full-scale negative on every input.
        for (int i = 0; i < N; i++)
            drive(1'b1, 16'sh8000, 16'sh8000, 16'sh8000, 1'b0, 1'b0);

        // Randomized traffic with occasional sync and reset.
        for (int i = 0; i < 2500; i++)
            drive($urandom_range(0, 9) < 7, 16'($urandom), 16'($urandom), 16'($urandom),
                  $urandom_range(0, 99) < 2, $urandom_range(0, 299) == 0);

        // Drain the pipeline.
        for (int i = 0; i < 6; i++) drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        check("pending decisions", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demixer.md
# demixer

Coherent QPSK demodulator for the QAM receive path, the counterpart of the transmit mixer. Multiplies each received sample by the local sine and cosine references and integrates each product over one symbol period (integrate-and-dump). At each symbol boundary it takes a sign decision per branch and emits the 2-bit symbol with a one-cycle valid strobe. It sits between the ADC/sample front end plus local NCO and the downstream bit sink.

## Interface
- `SAMPLES_PER_SYMBOL`, default 16: accepted samples per symbol; must be ≥ 1.
- `clk`  in  1: system clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `signal_in`  in  16: received sample, two's complement.
- `sine_in`  in  16: local sine reference, two's complement, phase-aligned to `signal_in`.
- `cosine_in`  in  16: local cosine reference, two's complement, phase-aligned to `signal_in`.
- `sample_valid`  in  1: `signal_in`, `sine_in` and `cosine_in` are valid this cycle.
- `sync`  in  1: symbol-boundary realign; restarts the symbol.
- `data_out`  out  2: decided symbol; bit0 is the cosine branch, bit1 is the sine branch.
- `data_valid`  out  1: one-cycle strobe; `data_out` is new.

## Operation
- Bit mapping matches the transmitter: bit0 = 1 means +cosine and bit0 = 0 means −cosine; bit1 works the same way with sine.
- **Stage 1:** on an accepted sample (`sample_valid` = 1), register both signed 32-bit products, `signal_in*cosine_in` and `signal_in*sine_in`.
  - Also register the sample's "last" flag (sample counter = N−1) and a stage-1 valid bit.
- **Stage 2:** when the stage-1 valid bit is set, add each product into its signed accumulator.
  - `ACC_W = 32 + clog2(SAMPLES_PER_SYMBOL)`. Products are sign-extended before the add. No overflow is possible.
- **Decision:** when the stage-1 entry carries the "last" flag:
  - `data_out[0] = (acc_cos + prod_cos >= 0)` and `data_out[1] = (acc_sin + prod_sin >= 0)`.
  - A sum of exactly 0 decides 1.
  - Both accumulators load 0 (dump), and `data_valid` pulses.
- **Sample counter:** 0..N−1, advances on each accepted sample and wraps to 0 after N−1.
  - `sample_valid` = 0 freezes the counter and inserts a bubble. Gaps of any length are allowed.
- **`sync` = 1:**
  - The counter is forced so that the current sample, if accepted, is sample 0.
  - Both accumulators clear, and the stage-1 entry is discarded. It is neither accumulated nor allowed to produce `data_valid`.
  - A partial symbol is dropped silently.
- **`rst`:** counter, accumulators, stage-1 registers, `data_out` (2'b00) and `data_valid` (0) all clear on the next edge.
  - Reset mid-symbol discards the partial symbol. The first symbol after reset starts with the first accepted sample.
- **`rst` and `sync` together:** `rst` wins.
- `data_out` holds its value between strobes.

## Timing
- Latency: the last sample of a symbol is accepted in cycle k, and `data_valid` = 1 with the new `data_out` in cycle k+2.
- Throughput: one sample per cycle. With `sample_valid` held high, `data_valid` pulses every N cycles.
- `data_valid` is never high for two consecutive cycles unless N = 1.
- Sample accepted in the same cycle as a dump decision: it feeds the fresh, cleared accumulator.

## Configuration
- `DEMIXER_SOFT_OUT_EN` defined:
  - Adds outputs `soft_cos_out` and `soft_sin_out`, each `ACC_W` bits, signed.
  - They are loaded with the final branch sums in the same cycle `data_valid` asserts.
  - They hold between strobes, reset to 0, and are intended for downstream soft decoding and SNR estimation.
- `DEMIXER_SOFT_OUT_EN` undefined: those ports and registers do not exist, and the hard-decision behaviour is identical.

## Test plan
- **Clean symbol stream.** N=16, `sample_valid` held high, references from a 16-sample-per-period sine/cosine table. `signal_in` = ±cos ± sin for the symbols 2'b00, 01, 10, 11 in turn → `data_out` 00, 01, 10, 11 in order, with `data_valid` pulsing every 16 cycles, 2 cycles after each symbol's last sample.
- **Input gaps.** Same stimulus with `sample_valid` toggling every cycle → identical decisions, `data_valid` every 32 cycles, no strobe during bubbles.
- **Zero input.** `signal_in` = 0 for a whole symbol → `data_out` = 2'b11. Under `DEMIXER_SOFT_OUT_EN`, both soft outputs = 0.
- **Sync mid-symbol.** Pulse `sync` on accepted sample 5 → no `data_valid` for the partial symbol. The next strobe comes 2 cycles after the 16th accepted sample counted from the sync sample, with the correct decision.
- **Reset mid-symbol.** Assert `rst` for one cycle after 7 samples → `data_out` = 00 and `data_valid` = 0 the next cycle. The following symbol of 16 samples decodes correctly, with no leftover energy (soft outputs match the ideal single-symbol sums).
- **Full-scale extremes.** `signal_in` = `cosine_in` = `sine_in` = −32768 for 16 samples → no overflow, `data_out` = 2'b11. Under `DEMIXER_SOFT_OUT_EN`, `soft_cos_out` = 16·2^30.
